// File: rtl/transpose_tile_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transpose_tile_buffer_pkg
// Description : Shared types and default sizes for the tile buffer and the
//               downstream transpose stage.
// Revision    : 1.0 - initial release
// ============================================================================
package transpose_tile_buffer_pkg;

    localparam int c_DATA_WIDTH = 64;
    localparam int c_NUM_MG     = 8;
    localparam int c_NUM_PE     = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_tile_buffer_tile_bank.sv
`default_nettype none
// ============================================================================
// Module      : tile_bank
// Description : Storage for one NUM_MG x NUM_PE tile plus its ctrl bit, written
//               one row at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_bank
    import transpose_tile_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NUM_MG     = c_NUM_MG,
    parameter int NUM_PE     = c_NUM_PE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_wr_en,
    input  logic [idx_width(NUM_MG)-1:0]         i_wr_row,
    input  logic [DATA_WIDTH-1:0]                i_wr_data [0:NUM_PE-1],
    input  logic                                 i_ctrl_wr_en,
    input  logic                                 i_ctrl,
    output logic [DATA_WIDTH-1:0]                o_elements [0:NUM_MG-1][0:NUM_PE-1],
    output logic                                 o_ctrl
);

    localparam int c_ROW_W = idx_width(NUM_MG);

    logic [DATA_WIDTH-1:0] r_mem [0:NUM_MG-1][0:NUM_PE-1];
    logic                  r_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_MG; r++) begin
                for (int c = 0; c < NUM_PE; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
            r_ctrl <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_MG; r++) begin
                if (i_wr_en && (i_wr_row == c_ROW_W'(r))) begin
                    for (int c = 0; c < NUM_PE; c++) begin
                        r_mem[r][c] <= i_wr_data[c];
                    end
                end
            end
            if (i_ctrl_wr_en) begin
                r_ctrl <= i_ctrl;
            end
        end
    end

    assign o_elements = r_mem;
    assign o_ctrl     = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/transpose_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module      : transpose_tile_buffer
// Description : Ping-pong buffer collecting rows into full tiles for the
//               transpose stage; one bank fills while the other drains.
// Revision    : 1.0 - initial release
// ============================================================================
module transpose_tile_buffer
    import transpose_tile_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NUM_MG     = c_NUM_MG,
    parameter int NUM_PE     = c_NUM_PE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_row [0:NUM_PE-1],
    input  logic                  in_ctrl,
    output logic                  out_val,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_elements [0:NUM_MG-1][0:NUM_PE-1],
    output logic                  out_ctrl
);

    localparam int                 c_ROW_W    = idx_width(NUM_MG);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(NUM_MG - 1);

    bank_state_t          r_state [0:1];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [c_ROW_W-1:0]   r_wr_row;

    logic w_accept;
    logic w_drain;
    logic w_first_row;

    assign in_ready    = (r_state[r_wr_ptr] != BANK_FULL);
    assign out_val     = (r_state[r_rd_ptr] == BANK_FULL);
    assign w_accept    = in_val && in_ready;
    assign w_drain     = out_val && out_ready;
    assign w_first_row = (r_wr_row == '0);

    // A draining bank is always FULL and the filling bank never is, so the two
    // state writes below can never target the same bank in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_row   <= '0;
        end else begin
            if (w_accept) begin
                if (r_wr_row == c_LAST_ROW) begin
                    r_state[r_wr_ptr] <= BANK_FULL;
                    r_wr_row          <= '0;
                    r_wr_ptr          <= ~r_wr_ptr;
                end else begin
                    if (w_first_row) begin
                        r_state[r_wr_ptr] <= BANK_FILLING;
                    end
                    r_wr_row <= r_wr_row + c_ROW_W'(1);
                end
            end
            if (w_drain) begin
                r_state[r_rd_ptr] <= BANK_EMPTY;
                r_rd_ptr          <= ~r_rd_ptr;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_IDX = (b != 0);

        logic                  w_wr_en;
        logic [DATA_WIDTH-1:0] w_elems [0:NUM_MG-1][0:NUM_PE-1];
        logic                  w_ctrl;

        assign w_wr_en = w_accept && (r_wr_ptr == c_IDX);

        tile_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_MG     (NUM_MG),
            .NUM_PE     (NUM_PE)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .i_wr_en      (w_wr_en),
            .i_wr_row     (r_wr_row),
            .i_wr_data    (in_row),
            .i_ctrl_wr_en (w_wr_en && w_first_row),
            .i_ctrl       (in_ctrl),
            .o_elements   (w_elems),
            .o_ctrl       (w_ctrl)
        );
    end

    always_comb begin
        out_ctrl = r_rd_ptr ? g_bank[1].w_ctrl : g_bank[0].w_ctrl;
        for (int r = 0; r < NUM_MG; r++) begin
            for (int c = 0; c < NUM_PE; c++) begin
                out_elements[r][c] = r_rd_ptr ? g_bank[1].w_elems[r][c]
                                              : g_bank[0].w_elems[r][c];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transpose_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_transpose_tile_buffer
// Description : Directed self-checking bench for transpose_tile_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transpose_tile_buffer;

    localparam int DW = 64;
    localparam int MG = 8;
    localparam int PE = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_val;
    logic          in_ready;
    logic [DW-1:0] in_row [0:PE-1];
    logic          in_ctrl;
    logic          out_val;
    logic          out_ready;
    logic [DW-1:0] out_elements [0:MG-1][0:PE-1];
    logic          out_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    transpose_tile_buffer #(
        .DATA_WIDTH (DW),
        .NUM_MG     (MG),
        .NUM_PE     (PE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_val       (in_val),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_ctrl      (in_ctrl),
        .out_val      (out_val),
        .out_ready    (out_ready),
        .out_elements (out_elements),
        .out_ctrl     (out_ctrl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r of a tile with base b carries b + r*16 + c in column c.
    task automatic send_row(input logic [63:0] base, input int r, input logic ctrl);
        in_val  = 1'b1;
        in_ctrl = ctrl;
        for (int c = 0; c < PE; c++) in_row[c] = base + 64'(r * 16 + c);
        tick();
        in_val  = 1'b0;
        in_ctrl = 1'b0;
    endtask

    task automatic chk_tile(input string tag, input logic [63:0] base, input logic ctrl);
        chk({tag, "_val"}, out_val, 1'b1);
        for (int r = 0; r < MG; r++) begin
            for (int c = 0; c < PE; c++) begin
                chk($sformatf("%s_el[%0d][%0d]", tag, r, c), out_elements[r][c],
                    base + 64'(r * 16 + c));
            end
        end
        chk({tag, "_ctrl"}, out_ctrl, ctrl);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_val    = 1'b0;
        in_ctrl   = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < PE; c++) in_row[c] = '0;
        tick();
        tick();
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_ctrl", out_ctrl, 1'b0);
        chk("rst_el00", out_elements[0][0], 64'h0);
        chk("rst_el77", out_elements[7][7], 64'h0);
        rst = 1'b0;
        tick();

        // Idle noise: rows without in_val and out_ready with nothing to drain.
        out_ready = 1'b1;
        for (int c = 0; c < PE; c++) in_row[c] = 64'hDEAD;
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_out_val", out_val, 1'b0);

        // Single tile, ctrl=1 on row 0.
        for (int r = 0; r < MG; r++) begin
            send_row(64'h0, r, r == 0);
            if (r == MG - 2) chk("single_pre_last", out_val, 1'b0);
        end
        chk_tile("single", 64'h0, 1'b1);
        tick();
        chk("single_hold", out_val, 1'b1);
        drain();
        chk("single_drained", out_val, 1'b0);
        chk("single_rdy", in_ready, 1'b1);

        // ctrl sampled on row 0 only.
        for (int r = 0; r < MG; r++) send_row(64'h100, r, r[0]);
        chk_tile("ctrl", 64'h100, 1'b0);
        drain();

        // Reset mid-fill after 3 rows.
        for (int r = 0; r < 3; r++) send_row(64'h200, r, 1'b1);
        chk("prefill_el00", out_elements[0][0], 64'h200);
        chk("prefill_val", out_val, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_val", out_val, 1'b0);
        chk("mid_rst_rdy", in_ready, 1'b1);
        chk("mid_rst_el00", out_elements[0][0], 64'h0);
        chk("mid_rst_el27", out_elements[2][7], 64'h0);
        chk("mid_rst_ctrl", out_ctrl, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        for (int r = 0; r < MG; r++) begin
            send_row(64'h300, r, 1'b1);
            if (r == MG - 2) chk("post_rst_pre_last", out_val, 1'b0);
        end
        chk_tile("post_rst", 64'h300, 1'b1);
        drain();

        // Backpressure: two tiles buffered, 17th row held off.
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < MG; r++) begin
                send_row(64'h400 + 64'(t * 'h100), r, t == 0);
                chk($sformatf("bp_rdy_t%0d_r%0d", t, r), in_ready, !(t == 1 && r == MG - 1));
            end
        end
        in_val  = 1'b1;
        in_ctrl = 1'b0;
        for (int c = 0; c < PE; c++) in_row[c] = 64'h600 + 64'(c);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_held_rdy", in_ready, 1'b0);
            chk("bp_stable_el00", out_elements[0][0], 64'h400);
            chk("bp_stable_el77", out_elements[7][7], 64'h477);
            chk("bp_stable_ctrl", out_ctrl, 1'b1);
        end
        in_val = 1'b0;
        chk_tile("bp_A", 64'h400, 1'b1);
        drain();
        chk_tile("bp_B", 64'h500, 1'b0);
        chk("bp_rdy_after", in_ready, 1'b1);
        drain();
        chk("bp_empty", out_val, 1'b0);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < MG; r++) begin
                send_row(64'h1000 * 64'(t + 1), r, t[0]);
                chk($sformatf("st_rdy_t%0d_r%0d", t, r), in_ready, 1'b1);
                chk($sformatf("st_val_t%0d_r%0d", t, r), out_val, r == MG - 1);
                if (r == MG - 1) chk_tile($sformatf("st_t%0d", t), 64'h1000 * 64'(t + 1), t[0]);
            end
        end
        tick();
        chk("st_end_val", out_val, 1'b0);
        out_ready = 1'b0;

        // Drain of tile A coincides with last row of tile B.
        for (int r = 0; r < MG; r++) send_row(64'h2000, r, 1'b1);
        for (int r = 0; r < MG - 1; r++) send_row(64'h3000, r, 1'b0);
        chk_tile("sim_A", 64'h2000, 1'b1);
        out_ready = 1'b1;
        send_row(64'h3000, MG - 1, 1'b0);
        out_ready = 1'b0;
        chk_tile("sim_B", 64'h3000, 1'b0);
        chk("sim_rdy", in_ready, 1'b1);
        drain();
        chk("sim_empty", out_val, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
